// File: rtl/kernel3_gmem_b_m_axi_burst_split.sv
// kernel3_gmem_b_m_axi_burst_split
// Turns one user read request (start address, length in beats) into a
// stream of AXI-legal sub-bursts for the gmem_B read-request FIFO. No
// sub-burst is longer than MAX_BURST_LEN beats or crosses a
// 2^BOUNDARY_LOG2-byte boundary.
// Optional feature: define KERNEL3_GMEM_B_BURST_SPLIT_STATS_EN to add the
// stat_req_cnt / stat_burst_cnt counters.
module kernel3_gmem_b_m_axi_burst_split #(
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 32,
  parameter int DATA_BYTES_LOG2 = 2,
  parameter int MAX_BURST_LEN   = 16,
  parameter int BOUNDARY_LOG2   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LEN_WIDTH-1:0]  in_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [7:0]            out_len,
  output logic                  out_last,
  output logic                  busy
`ifdef KERNEL3_GMEM_B_BURST_SPLIT_STATS_EN
  ,
  output logic [31:0]           stat_req_cnt,
  output logic [31:0]           stat_burst_cnt
`endif
);

  typedef enum logic {IDLE, SPLIT} state_t;

  // Clears the sub-beat address bits so every sub-burst starts beat-aligned.
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = {ADDR_WIDTH{1'b1}} << DATA_BYTES_LOG2;
  localparam logic [LEN_WIDTH-1:0]  MAX_LEN   = LEN_WIDTH'(MAX_BURST_LEN);
  localparam logic [BOUNDARY_LOG2:0] BOUNDARY_BYTES = {1'b1, {BOUNDARY_LOG2{1'b0}}};

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    rem_q, rem_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [7:0]              len_nxt;
  logic                    last_nxt;

  logic                    accept, fire;
  logic [LEN_WIDTH-1:0]    cur_chunk, adv_rem, calc_rem, chunk;
  logic [ADDR_WIDTH-1:0]   adv_addr, calc_addr;
  logic [BOUNDARY_LOG2:0]  btb_bytes, btb;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SPLIT);
  assign busy      = (state == SPLIT);

  // Chunk sizing: the same min() logic serves the first chunk of a new
  // request (from the input) and every following chunk (from the advanced
  // address/remainder of the chunk being handed off).
  always_comb begin
    accept    = in_valid && (state == IDLE) && clk_en;
    fire      = out_valid && out_ready && clk_en;
    cur_chunk = LEN_WIDTH'(out_len) + LEN_WIDTH'(1);
    adv_addr  = out_addr + (ADDR_WIDTH'(cur_chunk) << DATA_BYTES_LOG2);
    adv_rem   = rem_q - cur_chunk;
    calc_addr = (state == IDLE) ? (in_addr & BEAT_MASK) : adv_addr;
    calc_rem  = (state == IDLE) ? in_len : adv_rem;
    btb_bytes = BOUNDARY_BYTES - {1'b0, calc_addr[BOUNDARY_LOG2-1:0]};
    btb       = btb_bytes >> DATA_BYTES_LOG2;
    chunk     = calc_rem;
    if (MAX_LEN < chunk) chunk = MAX_LEN;
    if (LEN_WIDTH'(btb) < chunk) chunk = LEN_WIDTH'(btb);
  end

  // Next-state and output-register loading for the IDLE/SPLIT machine.
  always_comb begin
    state_nxt = state;
    addr_nxt  = out_addr;
    len_nxt   = out_len;
    last_nxt  = out_last;
    rem_nxt   = rem_q;
    case (state)
      IDLE: begin
        if (accept && (in_len != '0)) begin
          state_nxt = SPLIT;
          addr_nxt  = calc_addr;
          len_nxt   = 8'(chunk - LEN_WIDTH'(1));
          last_nxt  = (calc_rem == chunk);
          rem_nxt   = calc_rem;
        end
      end
      SPLIT: begin
        if (fire) begin
          if (out_last) begin
            state_nxt = IDLE;
          end else begin
            addr_nxt = calc_addr;
            len_nxt  = 8'(chunk - LEN_WIDTH'(1));
            last_nxt = (calc_rem == chunk);
            rem_nxt  = calc_rem;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; everything holds while clk_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out_addr <= '0;
      out_len  <= '0;
      out_last <= 1'b0;
      rem_q    <= '0;
    end else if (clk_en) begin
      state    <= state_nxt;
      out_addr <= addr_nxt;
      out_len  <= len_nxt;
      out_last <= last_nxt;
      rem_q    <= rem_nxt;
    end
  end

`ifdef KERNEL3_GMEM_B_BURST_SPLIT_STATS_EN
  // Counts non-empty accepted requests and sub-burst handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_req_cnt   <= '0;
      stat_burst_cnt <= '0;
    end else begin
      if (accept && (in_len != '0)) stat_req_cnt <= stat_req_cnt + 32'd1;
      if (fire) stat_burst_cnt <= stat_burst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kernel3_gmem_b_m_axi_burst_split.sv
// Directed testbench for kernel3_gmem_b_m_axi_burst_split with hand-computed
// sub-burst sequences.
module tb_kernel3_gmem_b_m_axi_burst_split;

  logic        clk = 1'b0;
  logic        reset, clk_en, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [63:0] in_addr, out_addr;
  logic [31:0] in_len;
  logic [7:0]  out_len;
`ifdef KERNEL3_GMEM_B_BURST_SPLIT_STATS_EN
  logic [31:0] stat_req_cnt, stat_burst_cnt;
`endif

  int checks = 0;
  int failures = 0;

  kernel3_gmem_b_m_axi_burst_split dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_len(out_len), .out_last(out_last), .busy(busy)
`ifdef KERNEL3_GMEM_B_BURST_SPLIT_STATS_EN
    , .stat_req_cnt(stat_req_cnt), .stat_burst_cnt(stat_burst_cnt)
`endif
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [31:0] l);
    in_valid = v;
    in_addr  = a;
    in_len   = l;
  endtask

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the handshake flags, and the sub-burst fields when one is offered.
  task automatic checkOutput(input string tag, input logic ev, input logic [63:0] ea,
                             input logic [7:0] el, input logic elast);
    checkEq({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ev});
    checkEq({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, !ev});
    checkEq({tag, ".busy"}, {63'd0, busy}, {63'd0, ev});
    if (ev) begin
      checkEq({tag, ".out_addr"}, out_addr, ea);
      checkEq({tag, ".out_len"}, {56'd0, out_len}, {56'd0, el});
      checkEq({tag, ".out_last"}, {63'd0, out_last}, {63'd0, elast});
    end
  endtask

  initial begin
    reset = 1'b1;
    clk_en = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 64'd0, 32'd0);
    step();
    step();
    checkOutput("reset", 1'b0, 64'd0, 8'd0, 1'b0);
    checkEq("reset.out_addr", out_addr, 64'd0);
    checkEq("reset.out_len", {56'd0, out_len}, 64'd0);
    checkEq("reset.out_last", {63'd0, out_last}, 64'd0);
    reset = 1'b0;

    // 40 beats from 0: 16 + 16 + 8.
    applyStimulus(1'b1, 64'h0, 32'd40);
    step();
    applyStimulus(1'b0, 64'h0, 32'd0);
    checkOutput("t1.b0", 1'b1, 64'h00, 8'd15, 1'b0);
    step();
    checkOutput("t1.b1", 1'b1, 64'h40, 8'd15, 1'b0);
    step();
    checkOutput("t1.b2", 1'b1, 64'h80, 8'd7, 1'b1);
    step();
    checkOutput("t1.idle", 1'b0, 64'd0, 8'd0, 1'b0);

    // 4 KB boundary split: 2 beats to 0x1000, then 8.
    applyStimulus(1'b1, 64'h0FF8, 32'd10);
    step();
    applyStimulus(1'b0, 64'h0, 32'd0);
    checkOutput("t2.b0", 1'b1, 64'h0FF8, 8'd1, 1'b0);
    step();
    checkOutput("t2.b1", 1'b1, 64'h1000, 8'd7, 1'b1);
    step();
    checkOutput("t2.idle", 1'b0, 64'd0, 8'd0, 1'b0);

    // Unaligned single beat.
    applyStimulus(1'b1, 64'h103, 32'd1);
    step();
    applyStimulus(1'b0, 64'h0, 32'd0);
    checkOutput("t3.b0", 1'b1, 64'h100, 8'd0, 1'b1);
    step();
    checkOutput("t3.idle", 1'b0, 64'd0, 8'd0, 1'b0);

    // Empty request is dropped.
    applyStimulus(1'b1, 64'h200, 32'd0);
    step();
    applyStimulus(1'b0, 64'h0, 32'd0);
    checkOutput("t4.c0", 1'b0, 64'd0, 8'd0, 1'b0);
    step();
    checkOutput("t4.c1", 1'b0, 64'd0, 8'd0, 1'b0);
`ifdef KERNEL3_GMEM_B_BURST_SPLIT_STATS_EN
    checkEq("t4.stat_req_cnt", {32'd0, stat_req_cnt}, 64'd3);
    checkEq("t4.stat_burst_cnt", {32'd0, stat_burst_cnt}, 64'd6);
`endif

    // Backpressure for 5 cycles on the first sub-burst of 32 beats.
    out_ready = 1'b0;
    applyStimulus(1'b1, 64'h0, 32'd32);
    step();
    applyStimulus(1'b0, 64'h0, 32'd0);
    checkOutput("t5.hold0", 1'b1, 64'h00, 8'd15, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t5.hold", 1'b1, 64'h00, 8'd15, 1'b0);
    end
    out_ready = 1'b1;
    step();
    checkOutput("t5.b1", 1'b1, 64'h40, 8'd15, 1'b1);
    step();
    checkOutput("t5.idle", 1'b0, 64'd0, 8'd0, 1'b0);

    // Reset during the second sub-burst, then a fresh request.
    applyStimulus(1'b1, 64'h0, 32'd40);
    step();
    applyStimulus(1'b0, 64'h0, 32'd0);
    checkOutput("t6.b0", 1'b1, 64'h00, 8'd15, 1'b0);
    step();
    checkOutput("t6.b1", 1'b1, 64'h40, 8'd15, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("t6.reset", 1'b0, 64'd0, 8'd0, 1'b0);
    checkEq("t6.reset.out_addr", out_addr, 64'd0);
    applyStimulus(1'b1, 64'h0FF0, 32'd5);
    step();
    applyStimulus(1'b0, 64'h0, 32'd0);
    checkOutput("t6.n0", 1'b1, 64'h0FF0, 8'd3, 1'b0);
    step();
    checkOutput("t6.n1", 1'b1, 64'h1000, 8'd0, 1'b1);
    step();
    checkOutput("t6.idle", 1'b0, 64'd0, 8'd0, 1'b0);

    // Clock enable low for 3 cycles mid-split.
    applyStimulus(1'b1, 64'h0, 32'd40);
    step();
    applyStimulus(1'b0, 64'h0, 32'd0);
    checkOutput("t7.b0", 1'b1, 64'h00, 8'd15, 1'b0);
    step();
    checkOutput("t7.b1", 1'b1, 64'h40, 8'd15, 1'b0);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t7.frozen", 1'b1, 64'h40, 8'd15, 1'b0);
    end
    clk_en = 1'b1;
    step();
    checkOutput("t7.b2", 1'b1, 64'h80, 8'd7, 1'b1);
    step();
    checkOutput("t7.idle", 1'b0, 64'd0, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
